// File: rtl/if_id_pipe_pkg.sv
// Shared constants, opcode encodings and FSM state type for the IF/ID pipeline register.
package if_id_pipe_pkg;

    localparam int unsigned DW = 16;
    localparam logic [DW-1:0] NOP_INSTR = 16'h0000;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_BR  = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;
    localparam logic [3:0] HLT_OPCODE = 4'hF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pipe_state_e;

    function automatic logic is_hlt(input logic [DW-1:0] instr);
        return (instr[DW-1:DW-4] == HLT_OPCODE);
    endfunction

endpackage

// File: rtl/if_id_pipe_sat_counter.sv
// Saturating up-counter with async active-low clear; reusable for stage perf counters.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic         w_at_max;

    assign w_at_max = (r_count == {W{1'b1}});

    // Count up on request, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {W{1'b0}};
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with stall/flush handling, HLT detection that freezes fetch,
// and a saturating count of injected bubbles.
module if_id_pipe
    import if_id_pipe_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] instr_IF,
    input  logic [DW-1:0] pc_IF,
    input  logic          stall,
    input  logic          flush,
    output logic [DW-1:0] instr_ID,
    output logic [DW-1:0] pc_ID,
    output logic          valid_ID,
    output logic          hlt_fetch,
    output logic [15:0]   bubble_cnt
);

    logic [DW-1:0] r_instr;
    logic [DW-1:0] r_pc;
    logic          r_valid;
    pipe_state_e   r_state;
    logic          w_bubble_inc;

    // A bubble is counted on every flush and on every non-stalled cycle spent halted.
    always_comb begin
        w_bubble_inc = 1'b0;
        if (flush) begin
            w_bubble_inc = 1'b1;
        end else if (!stall && (r_state == ST_HALT)) begin
            w_bubble_inc = 1'b1;
        end else begin
            w_bubble_inc = 1'b0;
        end
    end

    // Datapath registers and RUN/HALT state; flush beats stall beats capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NOP_INSTR;
            r_pc    <= {DW{1'b0}};
            r_valid <= 1'b0;
            r_state <= ST_RUN;
        end else if (flush) begin
            r_instr <= NOP_INSTR;
            r_pc    <= pc_IF;
            r_valid <= 1'b0;
            r_state <= ST_RUN;
        end else if (stall) begin
            r_instr <= r_instr;
            r_pc    <= r_pc;
            r_valid <= r_valid;
            r_state <= r_state;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_instr <= instr_IF;
                    r_pc    <= pc_IF;
                    r_valid <= 1'b1;
                    r_state <= is_hlt(instr_IF) ? ST_HALT : ST_RUN;
                end
                // Halted: instr_IF is ignored so nothing after HLT reaches decode.
                ST_HALT: begin
                    r_instr <= NOP_INSTR;
                    r_pc    <= r_pc;
                    r_valid <= 1'b0;
                    r_state <= ST_HALT;
                end
                default: begin
                    r_instr <= NOP_INSTR;
                    r_pc    <= r_pc;
                    r_valid <= 1'b0;
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    sat_counter #(
        .W (16)
    ) u_bubble_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_bubble_inc),
        .o_count (bubble_cnt)
    );

    assign instr_ID  = r_instr;
    assign pc_ID     = r_pc;
    assign valid_ID  = r_valid;
    assign hlt_fetch = (r_state == ST_HALT);

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed self-checking bench for if_id_pipe with hand-computed expectations.
module tb_if_id_pipe;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr_IF;
    logic [15:0] pc_IF;
    logic        stall;
    logic        flush;
    logic [15:0] instr_ID;
    logic [15:0] pc_ID;
    logic        valid_ID;
    logic        hlt_fetch;
    logic [15:0] bubble_cnt;

    int n_total;
    int n_bad;

    if_id_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_IF   (instr_IF),
        .pc_IF      (pc_IF),
        .stall      (stall),
        .flush      (flush),
        .instr_ID   (instr_ID),
        .pc_ID      (pc_ID),
        .valid_ID   (valid_ID),
        .hlt_fetch  (hlt_fetch),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic [15:0] e_instr, input logic [15:0] e_pc,
                            input logic e_valid, input logic e_hlt, input logic [15:0] e_cnt);
        check_val({tag, ".instr"}, {16'h0000, instr_ID}, {16'h0000, e_instr});
        check_val({tag, ".pc"},    {16'h0000, pc_ID},    {16'h0000, e_pc});
        check_val({tag, ".valid"}, {31'h0, valid_ID},    {31'h0, e_valid});
        check_val({tag, ".hlt"},   {31'h0, hlt_fetch},   {31'h0, e_hlt});
        check_val({tag, ".cnt"},   {16'h0000, bubble_cnt}, {16'h0000, e_cnt});
    endtask

    initial begin
        n_total  = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        instr_IF = 16'h7777;
        pc_IF    = 16'h0003;
        #12;
        check_id("reset0", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming
        instr_IF = 16'h1234; pc_IF = 16'h0001;
        step();
        check_id("stream1", 16'h1234, 16'h0001, 1'b1, 1'b0, 16'h0000);
        instr_IF = 16'h2345; pc_IF = 16'h0002;
        step();
        check_id("stream2", 16'h2345, 16'h0002, 1'b1, 1'b0, 16'h0000);

        // Stall holds everything, and a HLT seen while stalled is ignored
        instr_IF = 16'h1234; pc_IF = 16'h0005;
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_IF = (i == 1) ? 16'hF000 : 16'h6000 + 16'(i);
            pc_IF    = 16'h0010 + 16'(i);
            step();
            check_id("stall", 16'h1234, 16'h0005, 1'b1, 1'b0, 16'h0000);
        end
        stall = 1'b0;

        // Flush alone
        flush = 1'b1; instr_IF = 16'hABCD; pc_IF = 16'h0007;
        step();
        check_id("flush", 16'h0000, 16'h0007, 1'b0, 1'b0, 16'h0001);
        flush = 1'b0; instr_IF = 16'h1111; pc_IF = 16'h0008;
        step();
        check_id("post_flush", 16'h1111, 16'h0008, 1'b1, 1'b0, 16'h0001);

        // Flush together with stall
        flush = 1'b1; stall = 1'b1; instr_IF = 16'hABCD; pc_IF = 16'h0003;
        step();
        check_id("flush_stall", 16'h0000, 16'h0003, 1'b0, 1'b0, 16'h0002);
        flush = 1'b0; stall = 1'b0;

        // HLT enters ID once, then bubbles while halted
        instr_IF = 16'hF000; pc_IF = 16'h0009;
        step();
        check_id("hlt_cap", 16'hF000, 16'h0009, 1'b1, 1'b1, 16'h0002);
        for (int i = 0; i < 4; i++) begin
            instr_IF = 16'h5555; pc_IF = 16'h000A + 16'(i);
            step();
            check_id("hlt_bub", 16'h0000, 16'h0009, 1'b0, 1'b1, 16'h0003 + 16'(i));
        end
        stall = 1'b1;
        step();
        check_id("hlt_stall", 16'h0000, 16'h0009, 1'b0, 1'b1, 16'h0006);
        stall = 1'b0;

        // Flush cancels halt, then capture resumes
        flush = 1'b1; instr_IF = 16'hF000; pc_IF = 16'h0014;
        step();
        check_id("hlt_cancel", 16'h0000, 16'h0014, 1'b0, 1'b0, 16'h0007);
        flush = 1'b0; instr_IF = 16'h4321; pc_IF = 16'h0015;
        step();
        check_id("resume", 16'h4321, 16'h0015, 1'b1, 1'b0, 16'h0007);

        // HLT and flush on the same edge from RUN: flush wins
        flush = 1'b1; instr_IF = 16'hF123; pc_IF = 16'h0016;
        step();
        check_id("hlt_vs_flush", 16'h0000, 16'h0016, 1'b0, 1'b0, 16'h0008);
        flush = 1'b0; instr_IF = 16'h2222; pc_IF = 16'h0017;
        step();
        check_id("hlt_vs_flush2", 16'h2222, 16'h0017, 1'b1, 1'b0, 16'h0008);

        // Asynchronous reset while halted
        instr_IF = 16'hF000; pc_IF = 16'h001E;
        step();
        check_id("hlt_again", 16'hF000, 16'h001E, 1'b1, 1'b1, 16'h0008);
        #2;
        rst_n = 1'b0;
        #1;
        check_id("reset_halt", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of the bubble counter
        flush = 1'b1; instr_IF = 16'h0000; pc_IF = 16'h0000;
        for (int i = 0; i < 65534; i++) begin
            @(posedge clk);
        end
        #1;
        check_val("sat_fffe", {16'h0000, bubble_cnt}, 32'h0000FFFE);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("sat_ffff", {16'h0000, bubble_cnt}, 32'h0000FFFF);
        end
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_pipe.md
Name: if_id_pipe

Overview:
- Pipeline register between instruction fetch and decode.
- Captures the fetched instruction and PC each cycle and presents them to the decode stage with a valid bit.
- Honours stall (hold) and flush (squash to NOP) requests from the hazard/branch logic.
- Detects a fetched HLT opcode and drives the fetch stage's hlt input so the PC freezes, then keeps injecting bubbles until halted or flushed. Also keeps a saturating bubble counter for performance debug.

Parameters:
- DW, 16, instruction and PC width.
- NOP_INSTR, 16'h0000, encoding injected as a bubble (ADD R0,R0,R0; no architectural effect).
- HLT_OPCODE, 4'hF, value of instr[15:12] identifying HLT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_IF  in  DW  instruction from fetch stage.
- pc_IF  in  DW  PC value from fetch stage, paired with instr_IF.
- stall  in  1  hold all ID-side state this cycle.
- flush  in  1  squash the ID slot and cancel any pending halt (branch/jump resolved taken downstream).
- instr_ID  out  DW  registered instruction to decode.
- pc_ID  out  DW  registered PC to decode.
- valid_ID  out  1  instr_ID is a real instruction (0 = bubble).
- hlt_fetch  out  1  registered; drives fetch stage hlt, freezes PC.
- bubble_cnt  out  16  number of bubbles injected since reset; saturating.

Behaviour:
- Reset (async, rst_n=0), immediate:
  - instr_ID=NOP_INSTR, pc_ID=0, valid_ID=0.
  - hlt_fetch=0, state=RUN, bubble_cnt=0.
- Latency: instr_IF/pc_IF sampled at edge N appear on instr_ID/pc_ID after edge N.
- FSM states: RUN, HALT. hlt_fetch is 1 exactly when state==HALT (registered, no combinational path from instr_IF).
- Per-edge priority: flush > stall > normal capture.
- flush=1 (any state, regardless of stall):
  - instr_ID<=NOP_INSTR, valid_ID<=0, pc_ID<=pc_IF.
  - state<=RUN, so hlt_fetch deasserts the following cycle.
  - bubble_cnt increments.
- stall=1, flush=0:
  - instr_ID, pc_ID, valid_ID, state, bubble_cnt all hold.
  - A HLT present on instr_IF during stall is not decoded.
- Normal capture in RUN (stall=0, flush=0):
  - instr_ID<=instr_IF, pc_ID<=pc_IF, valid_ID<=1.
  - If instr_IF[15:12]==HLT_OPCODE, state<=HALT.
- Normal cycle in HALT (stall=0, flush=0):
  - instr_ID<=NOP_INSTR, valid_ID<=0, pc_ID holds.
  - bubble_cnt increments; state stays HALT.
  - This covers the instruction fetched in the cycle HLT entered ID, which must never reach decode.
- The HLT instruction itself passes into ID exactly once, valid_ID=1.
- HLT captured and flush asserted on the same edge: flush wins. No HLT captured, state=RUN.
- bubble_cnt saturates at 16'hFFFF and does not wrap.
- Reset mid-HALT: returns to RUN with hlt_fetch=0 immediately (async).
- X-safety: no output depends on instr_IF while state==HALT.

Decomposition:
- Shared pipeline package holds:
  - DW
  - NOP_INSTR
  - HLT_OPCODE and the other opcode constants
  - FSM state encoding (RUN=1'b0, HALT=1'b1)
- One natural sub-module: sat_counter (width parameter, inc enable, async active-low clear). It is reusable for other stage perf counters.
- Datapath registers and FSM stay in if_id_pipe.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with valid data on inputs -> immediately instr_ID=16'h0000, pc_ID=0, valid_ID=0, hlt_fetch=0, bubble_cnt=0.
- Streaming: instr_IF=16'h1234/16'h2345 with pc_IF=1/2 on consecutive edges -> instr_ID/pc_ID show each pair one cycle later, valid_ID=1, bubble_cnt=0.
- Stall: capture 16'h1234@pc 5, then stall=1 for 3 cycles while instr_IF changes -> instr_ID stays 16'h1234, pc_ID=5, bubble_cnt unchanged.
- Flush:
  - Flush alone: flush=1 with instr_IF=16'hABCD -> next cycle instr_ID=16'h0000, valid_ID=0, bubble_cnt=1.
  - Flush with stall: flush=1 and stall=1 together -> same squash result.
- Halt:
  - HLT capture: instr_IF=16'hF000 @pc 9 -> ID shows 16'hF000 valid, hlt_fetch=1 next cycle.
  - Bubbles: the following 4 cycles show NOP, valid_ID=0, bubble_cnt=4, hlt_fetch held.
- Halt cancel and saturation:
  - Cancel: in HALT, assert flush -> hlt_fetch=0 the cycle after, normal capture resumes.
  - Saturation: preload bubble_cnt to 16'hFFFE, apply 3 flushes -> bubble_cnt reads 16'hFFFF.
